// File: rtl/mips_pkg.sv
// Shared load/store definitions: memory op encoding, LSU FSM states,
// lane widths and small op-classification helpers.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_t;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } lsu_state_t;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  function automatic logic op_is_word(input mem_op_t op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic op_is_half(input mem_op_t op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic op_is_subword_store(input mem_op_t op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: extracts and extends a byte/halfword from a
// memory word for loads, and merges a store byte/halfword into a word for
// the read-modify-write path. Offset 0 is the most significant lane.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  mem_op_t     op_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [BYTE_W-1:0] byte_v;
  logic [HALF_W-1:0] half_v;

  // Select the addressed lanes of the word.
  always_comb begin
    byte_v = word_i[31:24];
    case (offset_i)
      2'd0: byte_v = word_i[31:24];
      2'd1: byte_v = word_i[23:16];
      2'd2: byte_v = word_i[15:8];
      default: byte_v = word_i[7:0];
    endcase
    half_v = offset_i[1] ? word_i[15:0] : word_i[31:16];
  end

  // Extend the selected lane for loads.
  always_comb begin
    load_data_o = word_i;
    case (op_i)
      OP_LH:   load_data_o = {{HALF_W{half_v[HALF_W-1]}}, half_v};
      OP_LHU:  load_data_o = {{HALF_W{1'b0}}, half_v};
      OP_LB:   load_data_o = {{(32-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
      OP_LBU:  load_data_o = {{(32-BYTE_W){1'b0}}, byte_v};
      default: load_data_o = word_i;
    endcase
  end

  // Replace the addressed lane with the new store data; SW replaces all.
  always_comb begin
    merged_o = word_i;
    case (op_i)
      OP_SB: begin
        case (offset_i)
          2'd0: merged_o[31:24] = store_data_i[7:0];
          2'd1: merged_o[23:16] = store_data_i[7:0];
          2'd2: merged_o[15:8]  = store_data_i[7:0];
          default: merged_o[7:0] = store_data_i[7:0];
        endcase
      end
      OP_SH: begin
        if (offset_i[1]) merged_o[15:0]  = store_data_i[15:0];
        else             merged_o[31:16] = store_data_i[15:0];
      end
      OP_SW:   merged_o = store_data_i;
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between EX/MEM and a word-wide big-endian data memory.
// Sub-word stores are done as a two-cycle read-modify-write.
// Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN -- when defined,
// misaligned requests return resp_exc=1 without touching memory; when
// undefined, the address is forced aligned to the access size.
// Handshake: a request transfers on a cycle where req_valid && req_ready;
// the response is a one-cycle resp_valid pulse with no backpressure.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_exc,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int AW = $clog2(MEM_BYTES);

  mem_op_t    op;
  lsu_state_t state_q, state_d;
  logic [31:0] aligned_addr;
  logic [1:0]  offset;
  logic        exc_req;
  logic [31:0] load_val, merged_val;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_exc_q, resp_exc_d;
  logic        unused_addr_hi;

  assign op             = mem_op_t'(req_op);
  assign aligned_addr   = {{(32-AW){1'b0}}, req_addr[AW-1:2], 2'b00};
  assign unused_addr_hi = ^req_addr[31:AW];

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign exc_req = (op_is_half(op) && req_addr[0]) ||
                   (op_is_word(op) && (req_addr[1:0] != 2'b00));
  assign offset  = req_addr[1:0];
`else
  assign exc_req = 1'b0;
  assign offset  = op_is_word(op) ? 2'b00 :
                   op_is_half(op) ? {req_addr[1], 1'b0} : req_addr[1:0];
`endif

  mem_lane_align u_align (
    .word_i       (mem_rdata),
    .offset_i     (offset),
    .op_i         (op),
    .store_data_i (req_wdata),
    .load_data_o  (load_val),
    .merged_o     (merged_val)
  );

  // Next-state, memory strobes and response staging.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_exc_d   = resp_exc_q;
    case (state_q)
      IDLE: begin
        req_ready = !rst;
        if (req_valid && !rst) begin
          if (exc_req) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'd0;
            resp_exc_d   = 1'b1;
          end else if (op_is_subword_store(op)) begin
            mem_read_en = 1'b1;
            mem_addr    = aligned_addr;
            wr_addr_d   = aligned_addr;
            wr_data_d   = merged_val;
            state_d     = RMW_WR;
          end else if (op == OP_SW) begin
            mem_write_en = 1'b1;
            mem_addr     = aligned_addr;
            mem_wdata    = req_wdata;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'd0;
            resp_exc_d   = 1'b0;
          end else begin
            mem_read_en  = 1'b1;
            mem_addr     = aligned_addr;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_val;
            resp_exc_d   = 1'b0;
          end
        end
      end
      RMW_WR: begin
        // A reset landing here drops the write and its response.
        if (!rst) begin
          mem_write_en = 1'b1;
          mem_addr     = wr_addr_q;
          mem_wdata    = wr_data_q;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'd0;
          resp_exc_d   = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_addr_q    <= 32'd0;
      wr_data_q    <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_exc_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_exc_q   <= resp_exc_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_exc   = resp_exc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural word memory, request driver task,
// response scoreboard (expected {exc, rdata} and expected cycle queues).
// Follows MEM_ACCESS_MISALIGN_TRAP_EN for misalignment expectations.
module tb_mem_access_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];

  logic [32:0] exp_q[$];
  int          exp_t_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          overlap_cnt = 0;

  logic        acc_rd, acc_wr;
  logic [31:0] acc_addr;

  mem_access_unit #(.DATA_WIDTH(32), .MEM_BYTES(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_exc     (resp_exc),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read, word write on the clock edge.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_write_en === 1'b1) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Drive one request, wait (bounded) for acceptance, record accept-cycle
  // memory strobes and queue the expected response (lat 0 = none).
  task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_exc, input int lat);
    int waited = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      acc_rd   = mem_read_en;
      acc_wr   = mem_write_en;
      acc_addr = mem_addr;
      if (lat > 0) begin
        exp_q.push_back({exp_exc, exp_rdata});
        exp_t_q.push_back(cyc + lat);
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Scoreboard: compare every response pulse, and watch for strobe overlap.
  always @(negedge clk) begin
    logic [32:0] e;
    int          t;
    if (mem_read_en === 1'b1 && mem_write_en === 1'b1) overlap_cnt++;
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        check("resp_data", {31'd0, resp_exc, resp_rdata}, {31'd0, e});
        check("resp_cycle", 64'(cyc), 64'(t));
      end
    end
  end

  initial begin
    int waited;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'hDEAD_BEEF;  // 0x004
    mem[4] = 32'h8A7F_1234;  // 0x010
    mem[8] = 32'h5566_7788;  // 0x020
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check("rst_rd_en", 64'(mem_read_en), 64'd0);
    check("rst_wr_en", 64'(mem_write_en), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // Back-to-back sub-word loads
    issue(OP_LB, 32'h010, 32'h0, 32'hFFFF_FF8A, 1'b0, 1);
    check("lb_rd_en", 64'(acc_rd), 64'd1);
    check("lb_addr", 64'(acc_addr), 64'h010);
    issue(OP_LBU, 32'h010, 32'h0, 32'h0000_008A, 1'b0, 1);
    issue(OP_LB, 32'h011, 32'h0, 32'h0000_007F, 1'b0, 1);
    issue(OP_LH, 32'h012, 32'h0, 32'h0000_1234, 1'b0, 1);
    check("lh_addr", 64'(acc_addr), 64'h010);

    // SB read-modify-write
    issue(OP_SB, 32'h011, 32'h0000_00CC, 32'h0, 1'b0, 2);
    check("sb_acc_rd", 64'(acc_rd), 64'd1);
    check("sb_acc_wr", 64'(acc_wr), 64'd0);
    @(negedge clk);
    check("sb_rmw_wr_en", 64'(mem_write_en), 64'd1);
    check("sb_rmw_rd_en", 64'(mem_read_en), 64'd0);
    check("sb_rmw_addr", 64'(mem_addr), 64'h010);
    check("sb_rmw_wdata", 64'(mem_wdata), 64'h8ACC_1234);
    check("sb_rmw_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    issue(OP_LW, 32'h010, 32'h0, 32'h8ACC_1234, 1'b0, 1);

    // SH followed immediately by SB into the same word
    issue(OP_SH, 32'h022, 32'h1234_BEEF, 32'h0, 1'b0, 2);
    issue(OP_SB, 32'h020, 32'hFFFF_FF11, 32'h0, 1'b0, 2);
    issue(OP_LW, 32'h020, 32'h0, 32'h1166_BEEF, 1'b0, 1);
    check("merge_word", 64'(mem[8]), 64'h1166_BEEF);

    // Misalignment
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    issue(OP_LW, 32'h006, 32'h0, 32'h0, 1'b1, 1);
    check("mis_lw_rd_en", 64'(acc_rd), 64'd0);
    check("mis_lw_wr_en", 64'(acc_wr), 64'd0);
    issue(OP_SH, 32'h005, 32'h0000_CAFE, 32'h0, 1'b1, 1);
    check("mis_sh_rd_en", 64'(acc_rd), 64'd0);
    check("mis_sh_wr_en", 64'(acc_wr), 64'd0);
    issue(OP_LW, 32'h004, 32'h0, 32'hDEAD_BEEF, 1'b0, 1);
`else
    issue(OP_LW, 32'h006, 32'h0, 32'hDEAD_BEEF, 1'b0, 1);
    check("mis_lw_addr", 64'(acc_addr), 64'h004);
    issue(OP_SH, 32'h005, 32'h0000_CAFE, 32'h0, 1'b0, 2);
    issue(OP_LW, 32'h004, 32'h0, 32'hCAFE_BEEF, 1'b0, 1);
`endif

    // SW then load back
    issue(OP_SW, 32'h030, 32'hA5A5_0F0F, 32'h0, 1'b0, 1);
    check("sw_wr_en", 64'(acc_wr), 64'd1);
    issue(OP_LHU, 32'h032, 32'h0, 32'h0000_0F0F, 1'b0, 1);

    // Reset during the RMW write cycle
    issue(OP_SB, 32'h013, 32'h0000_0077, 32'h0, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_wr_en", 64'(mem_write_en), 64'd0);
    check("abort_resp", 64'(resp_valid), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(req_ready), 64'd1);
    check("abort_resp2", 64'(resp_valid), 64'd0);
    check("abort_mem", 64'(mem[4]), 64'h8ACC_1234);
    @(posedge clk); #1;
    issue(OP_LW, 32'h010, 32'h0, 32'h8ACC_1234, 1'b0, 1);

    // Drain and report
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("no_overlap", 64'(overlap_cnt), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store unit between the EX/MEM pipeline register and the word-wide, big-endian data memory. It turns MIPS LW/LH/LHU/LB/LBU/SW/SH/SB requests into word reads and writes. Sub-word stores are performed as a two-cycle read-modify-write, because the memory only writes whole words. Loaded data is byte/halfword-extracted and extended, then returned to the writeback stage through a valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, word width; only 32 is supported.
- MEM_BYTES, 1024, addressable bytes; the address is truncated to $clog2(MEM_BYTES) bits before it is driven to memory.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit accepts a request this cycle
- req_op  in  3  mem_op_t: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and exceptions
- resp_exc  out  1  misaligned access; qualified by resp_valid
- mem_read_en  out  1  memory read enable
- mem_write_en  out  1  memory write enable
- mem_addr  out  32  word-aligned address, with bits [1:0] = 0
- mem_wdata  out  32  word written to memory
- mem_rdata  in  32  combinational read data for mem_addr

## Operation
- FSM states: IDLE, RMW_WR.
- Handshake:
  - req_ready = 1 only in IDLE and not in rst.
  - A request is accepted when req_valid && req_ready.
- Byte lanes are big-endian: offset 0 is bits [31:24], offset 3 is bits [7:0]. Halfword offset 0 is bits [31:16], offset 2 is bits [15:0].
- Loads:
  - In the accept cycle, drive mem_read_en=1 and mem_addr=aligned address.
  - Register the extracted lane.
  - LH/LB sign-extend; LHU/LBU zero-extend.
- SW: drive mem_write_en=1 with mem_wdata=req_wdata in the accept cycle.
- SH/SB:
  - Accept cycle: mem_read_en=1; capture mem_rdata and the merged word (new lane replacing the old one); go to RMW_WR.
  - RMW_WR: mem_write_en=1 with the merged word and the captured address; return to IDLE.
- Misalignment: a halfword op with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - Neither memory enable is asserted.
  - The response is returned with resp_exc=1 and resp_rdata=0.
- mem_read_en and mem_write_en are never both 1 in the same cycle.
- Reset:
  - All outputs reset to 0 except req_ready, which is 0 during rst and 1 in IDLE afterwards.
  - rst in RMW_WR aborts the write (mem_write_en=0 that cycle) and no response is issued. State goes to IDLE.

## Timing
- Loads, SW and exceptions: resp_valid goes high exactly 1 cycle after accept. Throughput is 1 request per cycle.
- SH/SB:
  - Write occurs 1 cycle after accept; resp_valid goes high 2 cycles after accept.
  - req_ready=0 in the RMW_WR cycle, so back-to-back sub-word stores run at one per 2 cycles.
- resp_rdata and resp_exc hold their value until the next response; they are meaningful only while resp_valid=1.
- A new request may be accepted in the same cycle that resp_valid is high for the previous one.
- No backpressure on the response side: the consumer must take resp_valid whenever it is asserted.

## Configuration
- MEM_ACCESS_MISALIGN_TRAP_EN defined: misaligned requests raise resp_exc as described in Operation.
- Undefined:
  - Misalignment is ignored. The address is forced aligned to the access size (halfword: addr[0] treated as 0; word: addr[1:0] treated as 0).
  - The access proceeds normally and resp_exc is tied 0.

## Structure
- Shared package mips_pkg holds:
  - the mem_op_t enum;
  - the lsu_state_t enum {IDLE, RMW_WR};
  - the constants BYTE_W=8 and HALF_W=16.
- Sub-module mem_lane_align (combinational). It serves both the load path and the RMW merge path.
  - Inputs: word, offset, op, store data.
  - Outputs: extracted/extended load value and merged store word.

## Test plan
- Memory word at 0x010 holds 0x8A7F_1234. Issue LB at 0x010, LBU at 0x010, LB at 0x011 and LH at 0x012 back-to-back. Required resp_rdata: 0xFFFF_FF8A, 0x0000_008A, 0x0000_007F, 0x0000_1234, each 1 cycle after its accept.
- Issue SB 0xCC at 0x011 over 0x8A7F_1234. Required: read in the accept cycle, write 0x8ACC_1234 in the next cycle, resp_valid the cycle after, req_ready=0 for one cycle. A following LW returns 0x8ACC_1234.
- Issue SH 0xBEEF at 0x022, immediately followed by SB 0x11 at 0x020. Required: final word 0x11xx_BEEF, with byte 1 unchanged. Confirm no write_en/read_en overlap.
- With the macro defined, issue LW at 0x006, then SH at 0x005. Required: each gives resp_valid with resp_exc=1 and resp_rdata=0 after 1 cycle; both memory enables stay 0.
- With the macro undefined, issue LW at 0x006. Required: mem_addr=0x004, resp_exc=0.
- Assert rst in the RMW_WR cycle of an SB. Required: no mem_write_en and no resp_valid. Memory is unchanged, and req_ready=1 in the cycle after rst deasserts.
